// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB completer memory and its register file.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_e;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;
    localparam int STRB_WIDTH     = APB_DATA_WIDTH / 8;

endpackage

// File: rtl/apb_slave_regfile.sv
// Word array behind the APB completer: byte-strobed synchronous write,
// asynchronous read, synchronous clear of every word while reset is held.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer memory: setup/access FSM with fixed wait states, byte strobes,
// and PSLVERR for misaligned, out-of-range and setup-less accesses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int         IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int         MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    apb_state_e            state;
    logic [3:0]            cnt;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  err;
    logic                  done;
    logic                  violation;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data;

    assign idx        = PADDR[ADDR_WIDTH-1:2];
    assign misaligned = |PADDR[1:0];

    // When DEPTH fills the whole index space no index can be out of range.
    generate
        if (DEPTH < 2 ** IDX_WIDTH) begin : g_range_check
            assign out_of_range = (idx >= IDX_WIDTH'(DEPTH));
        end else begin : g_full_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign err       = misaligned || out_of_range;
    assign done      = (state == ACCESS) && PSEL && PENABLE && (cnt == WAIT_LAST);
    assign violation = (state == IDLE) && PSEL && PENABLE;

    assign PREADY  = PRESETn && (done || violation);
    assign PSLVERR = PRESETn && ((done && err) || violation);
    assign mem_we  = PRESETn && done && PWRITE && !err;
    assign PRDATA  = (PRESETn && done && !PWRITE && !err) ? rd_data : '0;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state <= ACCESS;
                        cnt   <= '0;
                    end
                end
                ACCESS: begin
                    // Dropping PSEL mid-access is a master abort: leave silently.
                    if (!PSEL || done) begin
                        state <= IDLE;
                    end else if (cnt < WAIT_LAST) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb_slave_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (MEM_AW)
    ) u_regfile (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (mem_we),
        .waddr (idx[MEM_AW-1:0]),
        .wdata (PWDATA),
        .wstrb (PSTRB),
        .raddr (idx[MEM_AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: two instances (wait states 1 and 0), directed
// scenarios followed by random traffic checked against an array-based memory model.
module tb_apb_slave_mem;

    localparam int DEPTH = 64;
    localparam int WS0   = 1;
    localparam int WS1   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        pclk = 1'b0;
    logic        presetn [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [8:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] model [2][DEPTH];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_slave_mem #(
        .ADDR_WIDTH (9), .DATA_WIDTH (32), .DEPTH (DEPTH), .WAIT_STATES (WS0)
    ) u_dut0 (
        .PCLK (pclk), .PRESETn (presetn[0]), .PSEL (psel[0]), .PENABLE (penable[0]),
        .PWRITE (pwrite[0]), .PADDR (paddr[0]), .PWDATA (pwdata[0]), .PSTRB (pstrb[0]),
        .PRDATA (prdata[0]), .PREADY (pready[0]), .PSLVERR (pslverr[0])
    );

    apb_slave_mem #(
        .ADDR_WIDTH (8), .DATA_WIDTH (32), .DEPTH (DEPTH), .WAIT_STATES (WS1)
    ) u_dut1 (
        .PCLK (pclk), .PRESETn (presetn[1]), .PSEL (psel[1]), .PENABLE (penable[1]),
        .PWRITE (pwrite[1]), .PADDR (paddr[1][7:0]), .PWDATA (pwdata[1]), .PSTRB (pstrb[1]),
        .PRDATA (prdata[1]), .PREADY (pready[1]), .PSLVERR (pslverr[1])
    );

    function automatic int waitStates(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    task automatic pushExp(input int d, input logic [31:0] data, input logic err, input int due);
        exp_t e;
        e.data = data;
        e.err  = err;
        e.due  = due;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic modelTransfer(input int d, input bit wr, input int addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [31:0] rd, output logic err);
        err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        rd  = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model[d][addr / 4][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                rd = model[d][addr / 4];
            end
        end
    endtask

    task automatic clearModel(input int d);
        for (int i = 0; i < DEPTH; i++) model[d][i] = 32'h0;
    endtask

    // Called #1 after a rising edge; returns #1 after the completing edge with the bus idle.
    task automatic applyStimulus(input int d, input bit wr, input int addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        logic [31:0] rd;
        logic        err;
        logic [31:0] a;
        bit          seen;
        a = addr;
        modelTransfer(d, wr, addr, data, strb, rd, err);
        pushExp(d, rd, err, cyc + 1 + waitStates(d));
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a[8:0];
        pwdata[d]  = data;
        pstrb[d]   = strb;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge pclk);
            seen = pready[d];
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL pready_timeout dut%0d addr=%03h got=no_pready exp=pready", d, a[8:0]);
        end
        @(posedge pclk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic abortTransfer(input int d, input int addr, input logic [31:0] data);
        logic [31:0] a;
        a = addr;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = 1'b1;
        paddr[d]   = a[8:0];
        pwdata[d]  = data;
        pstrb[d]   = 4'hF;
        @(posedge pclk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Two consecutive setup-less access cycles: each must error, and the FSM must stay idle.
    task automatic violation(input int d);
        psel[d]    = 1'b1;
        penable[d] = 1'b1;
        pwrite[d]  = 1'b0;
        paddr[d]   = 9'h0;
        pushExp(d, 32'h0, 1'b1, cyc);
        @(posedge pclk); #1;
        pushExp(d, 32'h0, 1'b1, cyc);
        @(posedge pclk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic checkOutput(input int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (!presetn[d]) begin
            checks++;
            if (pready[d] || pslverr[d] || prdata[d] != 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_outputs dut%0d got=%b/%b/%08h exp=0/0/00000000",
                         d, pready[d], pslverr[d], prdata[d]);
            end
        end else if (pready[d]) begin
            if (sz == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pready dut%0d cycle=%0d got=pready exp=none", d, cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                checks += 3;
                if (prdata[d] !== e.data) begin
                    failures++;
                    $display("[TB] FAIL prdata dut%0d got=%08h exp=%08h", d, prdata[d], e.data);
                end
                if (pslverr[d] !== e.err) begin
                    failures++;
                    $display("[TB] FAIL pslverr dut%0d got=%b exp=%b", d, pslverr[d], e.err);
                end
                if (cyc != e.due) begin
                    failures++;
                    $display("[TB] FAIL pready_cycle dut%0d got=%0d exp=%0d", d, cyc, e.due);
                end
            end
        end else if (psel[d]) begin
            checks++;
            if (prdata[d] != 32'h0 || pslverr[d]) begin
                failures++;
                $display("[TB] FAIL idle_outputs dut%0d got=%08h/%b exp=00000000/0", d, prdata[d], pslverr[d]);
            end
        end
    endtask

    always @(negedge pclk) begin
        checkOutput(0);
        checkOutput(1);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          d;
        int          kind;
        int          addr;
        bit          wr;
        logic [31:0] data;
        logic [3:0]  strb;

        for (int i = 0; i < 2; i++) begin
            presetn[i] = 1'b0;
            psel[i]    = 1'b0;
            penable[i] = 1'b0;
            pwrite[i]  = 1'b0;
            paddr[i]   = 9'h0;
            pwdata[i]  = 32'h0;
            pstrb[i]   = 4'h0;
            clearModel(i);
        end
        // A setup-less access held during reset must still show no response.
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        presetn[0] = 1'b1;
        presetn[1] = 1'b1;
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        @(posedge pclk); #1;

        $display("[TB] directed sequence, one wait state");
        applyStimulus(0, 1'b0, 'h04, 32'h0, 4'h0);
        applyStimulus(0, 1'b1, 'h10, 32'hDEADBEEF, 4'hF);
        applyStimulus(0, 1'b0, 'h10, 32'h0, 4'h0);
        applyStimulus(0, 1'b1, 'h10, 32'h11223344, 4'b0101);
        applyStimulus(0, 1'b0, 'h10, 32'h0, 4'h0);
        applyStimulus(0, 1'b1, 'h12, 32'hFFFFFFFF, 4'hF);
        applyStimulus(0, 1'b1, 'h100, 32'hFFFFFFFF, 4'hF);
        applyStimulus(0, 1'b0, 'h10, 32'h0, 4'h0);
        applyStimulus(0, 1'b0, 'h1FC, 32'h0, 4'h0);

        @(posedge pclk); #1;
        violation(0);
        @(posedge pclk); #1;

        // Reset pulse during the wait cycle of a write to 0x20.
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b1;
        paddr[0]   = 9'h020;
        pwdata[0]  = 32'hA5A5A5A5;
        pstrb[0]   = 4'hF;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        presetn[0] = 1'b0;
        @(posedge pclk); #1;
        presetn[0] = 1'b1;
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        clearModel(0);
        applyStimulus(0, 1'b0, 'h20, 32'h0, 4'h0);
        applyStimulus(0, 1'b0, 'h10, 32'h0, 4'h0);

        abortTransfer(0, 'h30, 32'h12345678);
        applyStimulus(0, 1'b0, 'h30, 32'h0, 4'h0);

        $display("[TB] directed sequence, zero wait states, back-to-back");
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, 4 * i, 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 4 * i, 32'h0, 4'h0);
        abortTransfer(1, 'h08, 32'hCAFEF00D);
        applyStimulus(1, 1'b0, 'h08, 32'h0, 4'h0);
        violation(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind < 7) addr = 4 * int'($urandom_range(0, DEPTH - 1));
            else          addr = int'($urandom_range(0, (d == 0) ? 511 : 255));
            wr   = 1'($urandom_range(0, 1));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if (kind == 9) abortTransfer(d, addr, data);
            else           applyStimulus(d, wr, addr, data, strb);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
        end
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1'b0, 4 * i, 32'h0, 4'h0);

        repeat (5) @(posedge pclk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_responses got=%0d/%0d exp=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
